// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg
// Shared definitions for the MEM-stage load/store unit:
//   - funct3 load/store size/sign codes (F3_*)
//   - MEM-stage FSM state encoding (MS_*)
//   - addr_misaligned(): alignment rule for halfword/word accesses
package mem_stage_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

  // Halfword (LH/LHU/SH share the low funct3 bits) needs addr[0]=0.
  // Only the exact word code is checked for word alignment; the other
  // word-like codes fall through as LW without an alignment trap.
  function automatic logic addr_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic half_bad;
    logic word_bad;
    half_bad = (funct3[1:0] == 2'b01) & addr_lo[0];
    word_bad = (funct3 == F3_W) & (addr_lo != 2'b00);
    return half_bad | word_bad;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_fmt.sv
// lsu_lane_fmt
// Combinational byte-lane formatting for the MEM stage.
// Ports:
//   funct3_i      access size/sign
//   addr_lo_i     byte offset within the word
//   store_data_i  rs2 value for stores
//   rdata_i       read word from the data bus
//   be_o          byte enables for stores
//   wdata_o       lane-replicated store data
//   load_data_o   extracted and extended load value
module lsu_lane_fmt
  import mem_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    load_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_data_o = {24'd0, byte_sel};
      F3_HU:   load_data_o = {16'd0, half_sel};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
// MEM-stage consumer of the EX/MEM register: resolves branches/jumps
// (flush + PC redirect), runs data-memory accesses over a req/ack bus
// while stalling the pipeline, and registers the MEM/WB outputs.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   *_mem                            EX/MEM register outputs
//   exflush, pc_redirect             front-end redirect
//   mem_stall                        freezes PC and upstream pipeline regs
//   misaligned                       combinational misaligned-access flag
//   dmem_req/we/addr/wdata/be        registered data-bus request
//   dmem_ack, dmem_rdata             data-bus completion / read word
//   regwrite_wb, rd_wb, wb_data_wb   MEM/WB register
//
// state   | meaning
// --------+-----------------------------------------------------------
// MS_IDLE | no access in flight; aligned access here stalls and issues
// MS_BUSY | dmem_req held, waiting for dmem_ack
// MS_DONE | load data captured; stall released so the op retires
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RS_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   sum_mem,
  input  logic                  alu_branch_mem,
  input  logic [DATA_WIDTH-1:0] alu_result_mem,
  input  logic [RS_WIDTH-1:0]   rd_mem,
  input  logic                  branch_mem,
  input  logic                  memread_mem,
  input  logic                  memtoreg_mem,
  input  logic                  memwrite_mem,
  input  logic                  regwrite_mem,
  input  logic                  branchjalx_mem,
  input  logic                  alu2pc_mem,
  input  logic [PC_WIDTH-1:0]   pcplus4_mem,
  input  logic [DATA_WIDTH-1:0] store_data_mem,
  input  logic [2:0]            funct3_mem,
  output logic                  exflush,
  output logic [PC_WIDTH-1:0]   pc_redirect,
  output logic                  mem_stall,
  output logic                  misaligned,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [PC_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  regwrite_wb,
  output logic [RS_WIDTH-1:0]   rd_wb,
  output logic [DATA_WIDTH-1:0] wb_data_wb
);

  ms_state_e state_q, state_d;

  logic                  acc;
  logic                  mis;
  logic                  take;
  logic                  issue;
  logic [3:0]            be_fmt;
  logic [DATA_WIDTH-1:0] wdata_fmt;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic [DATA_WIDTH-1:0] load_q;

  logic                  req_q, we_q;
  logic [PC_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            be_q;

  logic                  regwrite_wb_q;
  logic [RS_WIDTH-1:0]   rd_wb_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

  assign acc = memread_mem | memwrite_mem;
  assign mis = acc & addr_misaligned(funct3_mem, alu_result_mem[1:0]);

  lsu_lane_fmt u_lane_fmt (
    .funct3_i     (funct3_mem),
    .addr_lo_i    (alu_result_mem[1:0]),
    .store_data_i (store_data_mem),
    .rdata_i      (dmem_rdata),
    .be_o         (be_fmt),
    .wdata_o      (wdata_fmt),
    .load_data_o  (load_fmt)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MS_IDLE;
    else        state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (acc && !mis) state_d = MS_BUSY;
      MS_BUSY: if (dmem_ack)    state_d = MS_DONE;
      MS_DONE:                  state_d = MS_IDLE;
      default:                  state_d = MS_IDLE;
    endcase
  end

  // outputs; a taken branch sharing the slot with a memory op waits for
  // DONE because the stall masks the flush
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      MS_IDLE: mem_stall = acc & ~mis;
      MS_BUSY: mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
    take        = (branch_mem & alu_branch_mem) | branchjalx_mem;
    exflush     = take & ~mem_stall;
    pc_redirect = alu2pc_mem ? {alu_result_mem[PC_WIDTH-1:1], 1'b0} : sum_mem;
    misaligned  = mis;
  end

  assign issue = (state_q == MS_IDLE) & (state_d == MS_BUSY);

  // bus request: loaded on issue, held through BUSY, dropped on ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      load_q  <= '0;
    end else if (issue) begin
      req_q   <= 1'b1;
      we_q    <= memwrite_mem;
      addr_q  <= {alu_result_mem[PC_WIDTH-1:2], 2'b00};
      wdata_q <= wdata_fmt;
      be_q    <= be_fmt;
    end else if (state_q == MS_BUSY && dmem_ack) begin
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      load_q <= load_fmt;
    end
  end

  // MEM/WB: bubble while stalled, wb data held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_wb_q <= 1'b0;
      rd_wb_q       <= '0;
      wb_data_q     <= '0;
    end else if (mem_stall) begin
      regwrite_wb_q <= 1'b0;
      rd_wb_q       <= '0;
    end else begin
      regwrite_wb_q <= regwrite_mem & (rd_mem != '0) & ~mis;
      rd_wb_q       <= rd_mem;
      wb_data_q     <= memtoreg_mem   ? load_q :
                       branchjalx_mem ? pcplus4_mem : alu_result_mem;
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign regwrite_wb = regwrite_wb_q;
  assign rd_wb       = rd_wb_q;
  assign wb_data_wb  = wb_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] sum_mem, alu_result_mem, pcplus4_mem, store_data_mem;
  logic        alu_branch_mem;
  logic [4:0]  rd_mem;
  logic        branch_mem, memread_mem, memtoreg_mem, memwrite_mem;
  logic        regwrite_mem, branchjalx_mem, alu2pc_mem;
  logic [2:0]  funct3_mem;
  logic        exflush, mem_stall, misaligned;
  logic [31:0] pc_redirect;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        regwrite_wb;
  logic [4:0]  rd_wb;
  logic [31:0] wb_data_wb;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic        last_we;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .sum_mem(sum_mem), .alu_branch_mem(alu_branch_mem),
    .alu_result_mem(alu_result_mem), .rd_mem(rd_mem),
    .branch_mem(branch_mem), .memread_mem(memread_mem),
    .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
    .regwrite_mem(regwrite_mem), .branchjalx_mem(branchjalx_mem),
    .alu2pc_mem(alu2pc_mem), .pcplus4_mem(pcplus4_mem),
    .store_data_mem(store_data_mem), .funct3_mem(funct3_mem),
    .exflush(exflush), .pc_redirect(pc_redirect),
    .mem_stall(mem_stall), .misaligned(misaligned),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .regwrite_wb(regwrite_wb), .rd_wb(rd_wb), .wb_data_wb(wb_data_wb)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (m_size(f3) == 2 && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int mask;
    if (m_size(f3) == 4) return 4'hF;
    mask = ((1 << m_size(f3)) - 1) << a[1:0];
    return mask[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    longint v;
    if (m_size(f3) == 1)      v = longint'(d & 32'hFF) * 64'h01010101;
    else if (m_size(f3) == 2) v = longint'(d & 32'hFFFF) * 64'h00010001;
    else                      v = longint'(d);
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    longint v;
    longint span;
    if (m_size(f3) == 4) return rd;
    span = (m_size(f3) == 1) ? 256 : 65536;
    v = longint'(rd) / (longint'(1) << (8 * a[1:0]));
    v = v % span;
    if (!f3[2] && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  // ---------------- drive helpers ----------------
  task automatic nop();
    sum_mem = 0; alu_branch_mem = 0; alu_result_mem = 0; rd_mem = 0;
    branch_mem = 0; memread_mem = 0; memtoreg_mem = 0; memwrite_mem = 0;
    regwrite_mem = 0; branchjalx_mem = 0; alu2pc_mem = 0; pcplus4_mem = 0;
    store_data_mem = 0; funct3_mem = 0;
  endtask

  task automatic set_mem(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] rd, input bit br);
    nop();
    memread_mem = ld; memwrite_mem = !ld; memtoreg_mem = ld; regwrite_mem = ld;
    funct3_mem = f3; alu_result_mem = addr; store_data_mem = sdata; rd_mem = rd;
    branch_mem = br; alu_branch_mem = br; sum_mem = 32'h500;
  endtask

  // Aligned access; nb = BUSY cycles, ack in the last. Called at posedge+1.
  task automatic mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] rdata,
                        input logic [4:0] rd, input int nb, input bit br,
                        input logic [31:0] e_wb);
    int stalls = 0;
    int busy = 0;
    int guard = 0;
    bit done = 0;
    set_mem(ld, f3, addr, sdata, rd, br);
    #1;
    chk("idle_misaligned", misaligned, 0);
    while (!done && guard < 40) begin
      guard++;
      if (mem_stall) begin
        stalls++;
        chk("flush_masked", exflush, 0);
        if (dmem_req) begin
          busy++;
          chk("bus_addr", dmem_addr, {addr[31:2], 2'b00});
          chk("bus_we", dmem_we, !ld);
          chk("wb_bubble", regwrite_wb, 0);
          if (!ld || m_size(f3) == 4) chk("bus_be", dmem_be, m_be(f3, addr));
          if (!ld) chk("bus_wdata", dmem_wdata, m_wdata(f3, sdata));
          last_be = dmem_be; last_wdata = dmem_wdata; last_we = dmem_we;
          if (busy == nb) begin dmem_ack = 1; dmem_rdata = rdata; end
        end else begin
          // ack while not BUSY must be ignored
          dmem_ack = 1; dmem_rdata = ~rdata;
        end
        @(posedge clk); #1;
        dmem_ack = 0; dmem_rdata = $urandom;
      end else done = 1;
    end
    if (!done) chk("stall_timeout", 1, 0);
    chk("stall_cycles", stalls, nb + 1);
    chk("done_req", dmem_req, 0);
    chk("done_flush", exflush, br);
    @(posedge clk); #1;
    chk("wb_regwrite", regwrite_wb, ld && rd != 0);
    chk("wb_rd", rd_wb, rd);
    chk("wb_data", wb_data_wb, e_wb);
    nop();
  endtask

  task automatic mis_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [4:0] rd);
    set_mem(ld, f3, addr, 32'h1234_5678, rd, 0);
    #1;
    chk("mis_flag", misaligned, 1);
    chk("mis_stall", mem_stall, 0);
    chk("mis_req", dmem_req, 0);
    @(posedge clk); #1;
    chk("mis_req_after", dmem_req, 0);
    chk("mis_regwrite", regwrite_wb, 0);
    nop();
  endtask

  // ---------------- single-cycle vector table ----------------
  typedef struct {
    logic rd_en, wr_en; logic [2:0] f3;
    logic br, abr, jalx, a2pc, rw; logic [4:0] rd;
    logic [31:0] alu, sum, pc4;
    logic e_mis, e_flush; logic [31:0] e_redir; logic e_rw; logic [31:0] e_wb;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0,0,3'd0, 0,0,1,1,1,5'd1, 32'h1235,     32'h999, 32'h40,  0,1,32'h1234, 1,32'h40};
    tbl[1] = '{0,0,3'd0, 1,1,0,0,0,5'd0, 32'h0,        32'h80,  32'h44,  0,1,32'h80,   0,32'h0};
    tbl[2] = '{0,0,3'd0, 1,0,0,0,0,5'd0, 32'h7,        32'h90,  32'h48,  0,0,32'h90,   0,32'h7};
    tbl[3] = '{0,0,3'd0, 0,0,0,0,1,5'd5, 32'h12345678, 32'h44,  32'h4C,  0,0,32'h44,   1,32'h12345678};
    tbl[4] = '{0,0,3'd0, 0,0,0,0,1,5'd0, 32'hAAAA5555, 32'h50,  32'h50,  0,0,32'h50,   0,32'hAAAA5555};
    tbl[5] = '{1,0,3'd2, 0,0,0,0,1,5'd3, 32'h101,      32'h60,  32'h60,  1,0,32'h60,   0,32'h101};
    tbl[6] = '{1,0,3'd1, 0,0,0,0,1,5'd4, 32'h203,      32'h64,  32'h64,  1,0,32'h64,   0,32'h203};
    tbl[7] = '{0,1,3'd2, 0,0,0,0,0,5'd0, 32'h102,      32'h68,  32'h68,  1,0,32'h68,   0,32'h102};
    tbl[8] = '{0,0,3'd0, 0,0,1,0,1,5'd1, 32'h0,        32'h300, 32'h104, 0,1,32'h300,  1,32'h104};
    tbl[9] = '{1,0,3'd5, 0,0,0,0,1,5'd7, 32'h105,      32'h6C,  32'h6C,  1,0,32'h6C,   0,32'h105};

    nop();
    dmem_ack = 0; dmem_rdata = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_regwrite", regwrite_wb, 0);
    chk("rst_rd", rd_wb, 0);
    chk("rst_wbdata", wb_data_wb, 0);
    chk("rst_stall", mem_stall, 0);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // table vectors
    for (int i = 0; i < 10; i++) begin
      nop();
      memread_mem = tbl[i].rd_en; memwrite_mem = tbl[i].wr_en; funct3_mem = tbl[i].f3;
      branch_mem = tbl[i].br; alu_branch_mem = tbl[i].abr; branchjalx_mem = tbl[i].jalx;
      alu2pc_mem = tbl[i].a2pc; regwrite_mem = tbl[i].rw; rd_mem = tbl[i].rd;
      alu_result_mem = tbl[i].alu; sum_mem = tbl[i].sum; pcplus4_mem = tbl[i].pc4;
      #1;
      chk($sformatf("v%0d_mis", i), misaligned, tbl[i].e_mis);
      chk($sformatf("v%0d_flush", i), exflush, tbl[i].e_flush);
      chk($sformatf("v%0d_redir", i), pc_redirect, tbl[i].e_redir);
      chk($sformatf("v%0d_stall", i), mem_stall, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_req", i), dmem_req, 0);
      chk($sformatf("v%0d_rw", i), regwrite_wb, tbl[i].e_rw);
      chk($sformatf("v%0d_rd", i), rd_wb, tbl[i].rd);
      chk($sformatf("v%0d_wb", i), wb_data_wb, tbl[i].e_wb);
    end
    nop();

    // hand sequences
    mem_op(1, 3'b010, 32'h100, 0, 32'hDEADBEEF, 5'd10, 3, 0, 32'hDEADBEEF);
    mem_op(1, 3'b000, 32'h103, 0, 32'h80112233, 5'd11, 1, 0, 32'hFFFFFF80);
    mem_op(1, 3'b100, 32'h103, 0, 32'h80112233, 5'd12, 2, 0, 32'h00000080);
    mem_op(0, 3'b001, 32'h202, 32'h0000ABCD, 0, 5'd0, 1, 0, 32'h202);
    chk("sh_be", last_be, 4'b1100);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_we", last_we, 1);
    mem_op(1, 3'b101, 32'h302, 0, 32'h9ABC1234, 5'd13, 2, 1, 32'h00009ABC);
    mis_op(1, 3'b010, 32'h101, 5'd9);

    // reset while BUSY
    set_mem(1, 3'b010, 32'h400, 0, 5'd6, 0);
    @(posedge clk); #1;
    chk("pre_rst_req", dmem_req, 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("async_req_drop", dmem_req, 0);
    nop();
    dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
    #4 rst_n = 1;
    @(posedge clk); @(posedge clk); #1;
    dmem_ack = 0;
    chk("post_rst_stall", mem_stall, 0);
    chk("post_rst_req", dmem_req, 0);
    chk("post_rst_be", dmem_be, 0);
    chk("post_rst_addr", dmem_addr, 0);
    chk("post_rst_rw", regwrite_wb, 0);
    chk("post_rst_wb", wb_data_wb, 0);
    mem_op(1, 3'b010, 32'h404, 0, 32'h0BADC0DE, 5'd6, 1, 0, 32'h0BADC0DE);

    // randomized against the model
    for (int k = 0; k < 60; k++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        logic br, abr, jalx, a2pc, rw;
        logic [31:0] alu, sum, pc4;
        logic [4:0] rd;
        br = 1'($urandom); abr = 1'($urandom); jalx = 1'($urandom);
        a2pc = 1'($urandom); rw = 1'($urandom); rd = 5'($urandom);
        alu = $urandom; sum = $urandom; pc4 = $urandom;
        nop();
        branch_mem = br; alu_branch_mem = abr; branchjalx_mem = jalx; alu2pc_mem = a2pc;
        regwrite_mem = rw; rd_mem = rd; alu_result_mem = alu; sum_mem = sum;
        pcplus4_mem = pc4;
        #1;
        chk("r_flush", exflush, (br & abr) | jalx);
        chk("r_redir", pc_redirect, a2pc ? (alu & ~32'd1) : sum);
        @(posedge clk); #1;
        chk("r_rw", regwrite_wb, rw && rd != 0);
        chk("r_wb", wb_data_wb, jalx ? pc4 : alu);
        nop();
      end else begin
        bit ld;
        logic [2:0] f3;
        logic [31:0] addr, sd, rdv;
        logic [4:0] rd;
        int pick;
        ld = 1'($urandom);
        pick = $urandom_range(0, ld ? 4 : 2);
        case (pick)
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        addr = $urandom & 32'h0000_FFFF;
        sd = $urandom; rdv = $urandom; rd = 5'($urandom);
        if (m_mis(f3, addr)) mis_op(ld, f3, addr, rd);
        else mem_op(ld, f3, addr, sd, rdv, rd, $urandom_range(1, 4), 0,
                    ld ? m_load(f3, addr, rdv) : addr);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs.
- Resolves branches and jumps and drives the EX-stage flush and PC redirect back to the front end.
- Runs data-memory loads and stores over a req/ack bus, stalling the pipeline until each access completes.
- Formats load data and registers the MEM/WB outputs.

Parameters:
PC_WIDTH, 32, PC/address width (`PC_WIDTH in riscv_def.v)
DATA_WIDTH, 32, register/bus data width (`REG_DATA_WIDTH)
RS_WIDTH, 5, register index width (`RS_WIDTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
sum_mem  in  PC_WIDTH  branch/JAL target
alu_branch_mem  in  1  branch condition true
alu_result_mem  in  DATA_WIDTH  ALU result / effective address
rd_mem  in  RS_WIDTH  destination register
branch_mem, memread_mem, memtoreg_mem, memwrite_mem, regwrite_mem, branchjalx_mem, alu2pc_mem  in  1 each  EX/MEM control bits
pcplus4_mem  in  PC_WIDTH  link value
store_data_mem  in  DATA_WIDTH  rs2 value for stores
funct3_mem  in  3  access size/sign
exflush  out  1  flush IF/ID, ID/EX, EX/MEM
pc_redirect  out  PC_WIDTH  redirect target
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
misaligned  out  1  one-cycle pulse on a misaligned access
dmem_req  out  1  bus request, registered
dmem_we  out  1  write enable, registered
dmem_addr  out  PC_WIDTH  word-aligned address, registered
dmem_wdata  out  DATA_WIDTH  lane-shifted store data, registered
dmem_be  out  4  byte enables, registered
dmem_ack  in  1  access complete; rdata valid for loads
dmem_rdata  in  DATA_WIDTH  read word
regwrite_wb  out  1  MEM/WB write enable
rd_wb  out  RS_WIDTH  MEM/WB destination register
wb_data_wb  out  DATA_WIDTH  MEM/WB writeback data

Behaviour:
- Reset (async, rst_n=0): state IDLE. All registered outputs are 0: dmem_*, regwrite_wb, rd_wb, wb_data_wb. Reset mid-access drops dmem_req immediately; any later ack is ignored.
- Memory access: acc = memread_mem | memwrite_mem.
- Alignment:
  - funct3 x01 (halfword) is misaligned if addr[0]=1.
  - funct3 010 (word) is misaligned if addr[1:0]≠0.
  - On a misaligned access: misaligned=1 (combinational), no bus request, no stall, regwrite_wb=0 for that instruction.
- FSM IDLE/BUSY/DONE:
  - IDLE, acc and aligned: mem_stall=1; next edge load dmem_* and go to BUSY.
  - BUSY: dmem_req held with all bus fields stable; mem_stall=1.
  - BUSY, dmem_ack=1: capture formatted read data; go to DONE.
  - DONE: mem_stall=0. The next edge advances EX/MEM and writes MEM/WB, then returns to IDLE.
  - dmem_ack outside BUSY is ignored.
  - Minimum cost of a memory op: 2 stall cycles.
- Byte lanes: dmem_addr = {addr[31:2],2'b00}.
  - SB: be = 0001<<addr[1:0], wdata = byte replicated ×4.
  - SH: be = 0011<<addr[1:0], wdata = half replicated ×2.
  - SW: be = 1111.
- Load format: select lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. funct3 011/11x are treated as LW.
- Branch resolution (combinational):
  - take = (branch_mem & alu_branch_mem) | branchjalx_mem.
  - exflush = take & ~mem_stall.
  - pc_redirect = alu2pc_mem ? {alu_result_mem[31:1],1'b0} : sum_mem.
  - Branch and memory control bits are mutually exclusive by decode. If both are set, the memory op is performed and take is masked until DONE.
- MEM/WB register, every edge:
  - While mem_stall=1: bubble (regwrite_wb=0, rd_wb=0, wb_data_wb held).
  - Otherwise: regwrite_wb = regwrite_mem & (rd_mem≠0) & ~misaligned; rd_wb = rd_mem.
  - wb_data_wb = memtoreg_mem ? load_data : (branchjalx_mem ? pcplus4_mem : alu_result_mem).

Decomposition:
- riscv_def.v gains:
  - funct3 load/store codes: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encodings: MS_IDLE, MS_BUSY, MS_DONE.
- One sub-module, lsu_lane_fmt: combinational byte-enable/store shift and load extract/extend.

Test Plan:
1. LW addr 0x100, ack after 3 BUSY cycles with rdata 0xDEADBEEF -> mem_stall high 4 cycles; dmem_be=1111; wb_data_wb=0xDEADBEEF, regwrite_wb=1 one cycle after DONE.
2. LB addr 0x103, rdata 0x80112233 -> wb_data_wb=0xFFFFFF80; LBU on the same word -> 0x00000080.
3. SH addr 0x202, data 0x0000ABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, regwrite_wb=0.
4. LW addr 0x101 -> misaligned pulse, dmem_req never asserts, mem_stall=0, regwrite_wb=0.
5. JALR with alu_result 0x1235, pcplus4 0x40 -> exflush=1, pc_redirect=0x1234, wb_data_wb=0x40. Taken BEQ with sum 0x80 -> pc_redirect=0x80. Not-taken branch -> exflush=0.
6. rst_n low while BUSY -> dmem_req drops asynchronously; later dmem_ack ignored; FSM in IDLE and all outputs 0 after release.
